muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 22 ++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master issues start/op/operands/rd; the slave returns status and the register-file write.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            we;
  logic [4:0]      wa;
  logic [1:0]      dbg_state;

  // Handshake: start is taken on a rising clk edge only while the unit is idle or in its
  // done cycle; done is a one-cycle pulse and result/wa stay valid until the next done.
  modport master (output start, op, a, b, rd,
                  input  busy, done, result, we, wa, dbg_state);
  modport slave  (input  start, op, a, b, rd,
                  output busy, done, result, we, wa, dbg_state);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide,
// both on magnitudes with a sign fix-up, fixed 33-cycle start-to-done latency.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

    state_e          state_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [4:0]      rd_q, wa_q;
    logic            neg_lo_q, neg_r_q;
    logic            busy_q, done_q, we_q;

    logic            accept, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   msum, dsh, ddiff;
    logic            ge;
    logic [XLEN-1:0] hi_nx, lo_nx, q_s, r_s, final_res;
    logic [2*XLEN-1:0] prod, prod_s;

    assign accept = bus.start && (state_q != S_RUN);

    // Mul: a signed except MULHU; b signed only for MUL/MULH. Div: signed when op[0]==0.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (bus.op[2]) begin
            a_signed = ~bus.op[0];
            b_signed = ~bus.op[0];
        end else begin
            a_signed = (bus.op[1:0] != 2'b11);
            b_signed = ~bus.op[1];
        end
    end

    assign a_neg = a_signed & bus.a[XLEN-1];
    assign b_neg = b_signed & bus.b[XLEN-1];
    assign a_mag = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_mag = b_neg ? (~bus.b + 1'b1) : bus.b;

    // hi holds the running partial product / partial remainder, lo the multiplier / quotient.
    always_comb begin
        msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        dsh   = {hi_q, lo_q[XLEN-1]};
        ddiff = dsh - {1'b0, opnd_q};
        ge    = ~ddiff[XLEN];
        if (op_q[2]) begin
            hi_nx = ge ? ddiff[XLEN-1:0] : dsh[XLEN-1:0];
            lo_nx = {lo_q[XLEN-2:0], ge};
        end else begin
            hi_nx = msum[XLEN:1];
            lo_nx = {msum[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod   = {hi_nx, lo_nx};
        prod_s = neg_lo_q ? (~prod + 1'b1) : prod;
        q_s    = neg_lo_q ? (~lo_nx + 1'b1) : lo_nx;
        r_s    = neg_r_q ? (~hi_nx + 1'b1) : hi_nx;
        final_res = '0;
        case (op_q)
            3'd0:                final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = q_s;
            default:             final_res = r_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            wa_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            if (state_q == S_RUN) begin
                hi_q  <= hi_nx;
                lo_q  <= lo_nx;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_q  <= S_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    we_q     <= (rd_q != 5'd0);
                    result_q <= final_res;
                    wa_q     <= rd_q;
                end
            end else if (accept) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                op_q    <= bus.op;
                rd_q    <= bus.rd;
                hi_q    <= '0;
                // Divide by zero keeps the quotient unnegated (all ones) and the
                // remainder sign of a, which turns |a| back into a.
                if (bus.op[2]) begin
                    lo_q     <= a_mag;
                    opnd_q   <= b_mag;
                    neg_lo_q <= (a_neg ^ b_neg) && (bus.b != '0);
                    neg_r_q  <= a_neg;
                end else begin
                    lo_q     <= b_mag;
                    opnd_q   <= a_mag;
                    neg_lo_q <= a_neg ^ b_neg;
                    neg_r_q  <= 1'b0;
                end
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.we        = we_q;
    assign bus.result    = result_q;
    assign bus.wa        = wa_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, write-enable and reset/abort behaviour.
module tb_muldiv_unit;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the next rising edge samples start.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.rd    = rd;
        bus.start = 1'b1;
    endtask

    // Counts cycles from the start cycle until done; scrambles inputs after start is taken
    // and optionally re-pulses start with other operands at cycle inj_at.
    task automatic wait_done(input int inj_at, output int cyc, output int busy_n,
                             output int we_n, output logic busy1);
        cyc = 0; busy_n = 0; we_n = 0; busy1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a     = $urandom;
                bus.b     = $urandom;
                bus.op    = 3'($urandom_range(0, 7));
                bus.rd    = 5'($urandom_range(0, 31));
                busy1     = bus.busy;
            end
            if (inj_at != 0 && k == inj_at) begin
                bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'd1000; bus.b = 32'd3; bus.rd = 5'd9;
            end
            if (inj_at != 0 && k == inj_at + 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.we) we_n++;
            if (bus.done) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) cyc = 41;
    endtask

    task automatic run_std(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int   cyc, busy_n, we_n;
        logic busy1;
        issue(op, a, b, rd);
        wait_done(0, cyc, busy_n, we_n, busy1);
        chk({tag, "/latency"}, 32'(cyc), 32'd33);
        chk({tag, "/busy_cycles"}, 32'(busy_n), 32'd32);
        chk({tag, "/result"}, bus.result, exp);
        chk({tag, "/we"}, {31'd0, bus.we}, {31'd0, rd != 5'd0});
        chk({tag, "/wa"}, {27'd0, bus.wa}, {27'd0, rd});
        @(negedge clk);
        chk({tag, "/done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "/result_hold"}, bus.result, exp);
    endtask

    initial begin
        int   cyc, busy_n, we_n, done_n;
        logic busy1;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.rd = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst/busy", {31'd0, bus.busy}, 32'd0);
        chk("rst/done", {31'd0, bus.done}, 32'd0);
        chk("rst/we", {31'd0, bus.we}, 32'd0);
        chk("rst/result", bus.result, 32'd0);
        chk("rst/wa", {27'd0, bus.wa}, 32'd0);
        chk("rst/state", {30'd0, bus.dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_std("mul_7x6", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42);
        run_std("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd6, 32'hFFFF_FFF1);
        run_std("mulh_m1m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
        run_std("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        run_std("mulh_2xm1", 3'd1, 32'd2, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
        run_std("mulhsu_2xff", 3'd2, 32'd2, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
        run_std("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF);
        run_std("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD);
        run_std("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
        run_std("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd10, 32'd14);
        run_std("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2);
        run_std("divu_by0", 3'd5, 32'd9, 32'd0, 5'd11, 32'hFFFF_FFFF);
        run_std("remu_by0", 3'd7, 32'd9, 32'd0, 5'd11, 32'd9);
        run_std("div_m9_by0", 3'd4, 32'hFFFF_FFF7, 32'd0, 5'd12, 32'hFFFF_FFFF);
        run_std("rem_m9_by0", 3'd6, 32'hFFFF_FFF7, 32'd0, 5'd12, 32'hFFFF_FFF7);
        run_std("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run_std("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
        run_std("mul_rd0", 3'd0, 32'd3, 32'd3, 5'd0, 32'd9);

        // start during RUN is ignored, then a back-to-back start in the DONE cycle
        issue(3'd0, 32'd7, 32'd6, 5'd3);
        wait_done(10, cyc, busy_n, we_n, busy1);
        chk("b2b/first_latency", 32'(cyc), 32'd33);
        chk("b2b/first_result", bus.result, 32'd42);
        chk("b2b/first_wa", {27'd0, bus.wa}, 32'd3);
        issue(3'd5, 32'd100, 32'd7, 5'd4);
        wait_done(0, cyc, busy_n, we_n, busy1);
        chk("b2b/busy_next_edge", {31'd0, busy1}, 32'd1);
        chk("b2b/second_latency", 32'(cyc), 32'd33);
        chk("b2b/second_busy_cycles", 32'(busy_n), 32'd32);
        chk("b2b/second_result", bus.result, 32'd14);
        chk("b2b/second_wa", {27'd0, bus.wa}, 32'd4);
        @(negedge clk);
        @(negedge clk);
        chk("b2b/idle_state", {30'd0, bus.dbg_state}, 32'd0);

        // reset asserted at cycle 20 of RUN aborts without a write
        issue(3'd0, 32'd7, 32'd6, 5'd7);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("abort/busy", {31'd0, bus.busy}, 32'd0);
        chk("abort/done", {31'd0, bus.done}, 32'd0);
        chk("abort/result", bus.result, 32'd0);
        chk("abort/state", {30'd0, bus.dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        we_n = 0; done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.we) we_n++;
            if (bus.done) done_n++;
        end
        chk("abort/no_we", 32'(we_n), 32'd0);
        chk("abort/no_done", 32'(done_n), 32'd0);

        // start held across reset release is taken only at an edge with reset high
        reset = 1'b0;
        issue(3'd0, 32'd2, 32'd3, 5'd2);
        @(negedge clk);
        chk("rst_start/ignored", {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;
        wait_done(0, cyc, busy_n, we_n, busy1);
        chk("rst_start/latency", 32'(cyc), 32'd33);
        chk("rst_start/result", bus.result, 32'd6);
        chk("rst_start/we", {31'd0, bus.we}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
